// File: rtl/jk_drive_seq.sv
// rtl/jk_drive_seq.sv - J/K excitation sequencer moving an external JK bank to a requested target.
// Optional build macro JK_DRIVE_TOGGLE_EN selects toggle (J=K=1) encoding for changing bits.
module jk_drive_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_target,
   input  logic             req_mode,
   output logic             drive_en,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] shadow,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STEP,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] nxt;

   // Count mode uses an unsigned compare, so it never wraps around.
   always_comb begin
      if (!mode_q)
         nxt = target_q;
      else if (target_q > shadow_q)
         nxt = shadow_q + WIDTH'(1);
      else
         nxt = shadow_q - WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         shadow_q <= '0;
         target_q <= '0;
         mode_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         target_q <= target_d;
         mode_q   <= mode_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      target_d = target_q;
      mode_d   = mode_q;
      drive_en = 1'b0;
      done     = 1'b0;
      j        = '0;
      k        = '0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               target_d = req_target;
               mode_d   = req_mode;
               state_d  = (req_target == shadow_q) ? S_DONE : S_STEP;
            end
         end
         S_STEP: begin
            drive_en = 1'b1;
`ifdef JK_DRIVE_TOGGLE_EN
            j = shadow_q ^ nxt;
            k = shadow_q ^ nxt;
`else
            j = ~shadow_q & nxt;
            k = shadow_q & ~nxt;
`endif
            shadow_d = nxt;
            if (nxt == target_q)
               state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign shadow    = shadow_q;

endmodule

// File: tb/tb_jk_drive_seq.sv
// tb/tb_jk_drive_seq.sv - self-checking bench for jk_drive_seq (table, random and reset-abort cases).
module tb_jk_drive_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_target;
   logic       req_mode;
   logic       drive_en;
   logic [3:0] j, k, shadow;
   logic       busy, done;

   int checks = 0;
   int errors = 0;
   logic [3:0] sh_m;

   always #5 clk = ~clk;

   jk_drive_seq #(.WIDTH(4)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_target(req_target), .req_mode(req_mode), .drive_en(drive_en),
      .j(j), .k(k), .shadow(shadow), .busy(busy), .done(done)
   );

   typedef struct {
      logic [3:0] tgt;
      logic       mode;
      int         steps;
      logic [3:0] fin;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Excitation table lookup, one bit at a time: returns {j, k}.
   function automatic logic [7:0] exc(input logic [3:0] cur, input logic [3:0] nx);
      logic [3:0] ej, ek;
      ej = '0;
      ek = '0;
      for (int b = 0; b < 4; b++) begin
         case ({cur[b], nx[b]})
`ifdef JK_DRIVE_TOGGLE_EN
            2'b01, 2'b10: begin ej[b] = 1'b1; ek[b] = 1'b1; end
`else
            2'b01: ej[b] = 1'b1;
            2'b10: ek[b] = 1'b1;
`endif
            default: ;
         endcase
      end
      return {ej, ek};
   endfunction

   task automatic busy_inputs(input bit noise);
      if (noise) begin
         req_valid  = 1'($urandom);
         req_target = 4'($urandom);
         req_mode   = 1'($urandom);
      end else begin
         req_valid = 1'b0;
      end
   endtask

   // Issue one request from a negedge with the DUT idle and walk it cycle by cycle.
   task automatic do_req(input logic [3:0] t, input logic m, input bit noise, output int ndrive);
      logic [3:0] cur, nx;
      logic [7:0] e;
      ndrive = 0;
      chk("ready_before", int'(req_ready), 1);
      req_valid  = 1'b1;
      req_target = t;
      req_mode   = m;
      @(negedge clk);
      cur = sh_m;
      while (cur != t) begin
         busy_inputs(noise);
         if (!m) nx = t;
         else if (t > cur) nx = cur + 4'd1;
         else nx = cur - 4'd1;
         e = exc(cur, nx);
         ndrive += int'(drive_en);
         chk("step_drive_en", int'(drive_en), 1);
         chk("step_j", int'(j), int'(e[7:4]));
         chk("step_k", int'(k), int'(e[3:0]));
         chk("step_shadow", int'(shadow), int'(cur));
         chk("step_busy", int'(busy), 1);
         chk("step_done", int'(done), 0);
         chk("step_ready", int'(req_ready), 0);
         cur = nx;
         @(negedge clk);
      end
      busy_inputs(noise);
      chk("done_pulse", int'(done), 1);
      chk("done_drive_en", int'(drive_en), 0);
      chk("done_jk", int'({j, k}), 0);
      chk("done_busy", int'(busy), 1);
      chk("done_ready", int'(req_ready), 0);
      chk("done_shadow", int'(shadow), int'(t));
      req_valid = 1'b0;
      @(negedge clk);
      chk("idle_done", int'(done), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_ready", int'(req_ready), 1);
      chk("idle_shadow", int'(shadow), int'(t));
      sh_m = t;
   endtask

   vec_t vecs[10];
   int   nd;

   initial begin
      vecs[0] = '{4'hA, 1'b0, 1,  4'hA};
      vecs[1] = '{4'h5, 1'b0, 1,  4'h5};
      vecs[2] = '{4'h0, 1'b0, 1,  4'h0};
      vecs[3] = '{4'h3, 1'b1, 3,  4'h3};
      vecs[4] = '{4'h1, 1'b1, 2,  4'h1};
      vecs[5] = '{4'h1, 1'b0, 0,  4'h1};
      vecs[6] = '{4'hF, 1'b1, 14, 4'hF};
      vecs[7] = '{4'h0, 1'b1, 15, 4'h0};
      vecs[8] = '{4'h0, 1'b1, 0,  4'h0};
      vecs[9] = '{4'h9, 1'b1, 9,  4'h9};

      reset = 1'b1;
      req_valid = 1'b0;
      req_target = '0;
      req_mode = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_shadow", int'(shadow), 0);
      chk("rst_jk", int'({j, k}), 0);
      chk("rst_drive_en", int'(drive_en), 0);
      chk("rst_ready", int'(req_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      sh_m = 4'h0;

      for (int i = 0; i < 10; i++) begin
         do_req(vecs[i].tgt, vecs[i].mode, (i % 2) == 1, nd);
         chk($sformatf("vec%0d_drive_cycles", i), nd, vecs[i].steps);
         chk($sformatf("vec%0d_final", i), int'(shadow), int'(vecs[i].fin));
      end

      for (int i = 0; i < 40; i++)
         do_req(4'($urandom), 1'($urandom), 1'b1, nd);

      // Abort a 0 -> F count after four drive cycles; a busy-time request must be dropped.
      do_req(4'h0, 1'b0, 1'b0, nd);
      req_valid  = 1'b1;
      req_target = 4'hF;
      req_mode   = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         req_valid  = (i == 1);
         req_target = 4'h0;
         req_mode   = 1'b0;
         chk("abort_drive_en", int'(drive_en), 1);
         chk("abort_shadow", int'(shadow), i);
         if (i < 3) @(negedge clk);
      end
      req_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_ready", int'(req_ready), 1);
      chk("abort_busy", int'(busy), 0);
      chk("abort_shadow0", int'(shadow), 0);
      chk("abort_jk", int'({j, k}), 0);
      chk("abort_drive_off", int'(drive_en), 0);
      chk("abort_no_done", int'(done), 0);
      reset = 1'b0;
      sh_m = 4'h0;
      @(negedge clk);
      chk("post_abort_done", int'(done), 0);
      do_req(4'h2, 1'b1, 1'b0, nd);
      chk("post_abort_cycles", nd, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
